// File: rtl/seven_seg_pkg.sv
// Shared constants for the MM:SS seven-segment scanner: segment codes,
// digit-slot indices and vector widths.
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_N = 4;

  // Segment codes, gfedcba, active-high
  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

  typedef enum logic [1:0] {
    DIG_SEC_ONES = 2'd0,
    DIG_SEC_TENS = 2'd1,
    DIG_MIN_ONES = 2'd2,
    DIG_MIN_TENS = 2'd3
  } dig_idx_e;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Combinational BCD nibble to active-high segment decoder; non-BCD nibbles
// decode to a dash.
module bcd_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0]       i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_DASH;
    case (i_nibble)
      4'd0:    o_seg_c = SEG_0;
      4'd1:    o_seg_c = SEG_1;
      4'd2:    o_seg_c = SEG_2;
      4'd3:    o_seg_c = SEG_3;
      4'd4:    o_seg_c = SEG_4;
      4'd5:    o_seg_c = SEG_5;
      4'd6:    o_seg_c = SEG_6;
      4'd7:    o_seg_c = SEG_7;
      4'd8:    o_seg_c = SEG_8;
      4'd9:    o_seg_c = SEG_9;
      default: o_seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit MM:SS multiplexed display driver with per-slot dead time and
// frame-latched BCD shadows. Optional macro: LEADING_ZERO_BLANK_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 12000,
  parameter int unsigned DEAD_CLKS      = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       min_bcd_i,
  input  logic [7:0]       sec_bcd_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_o,
  output logic [DIG_N-1:0] dig_o,
  output logic             colon_o,
  output logic             frame_o
);

  localparam int unsigned      DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_LIM  = DIV_W'(DEAD_CLKS);
  localparam logic [SEG_W-1:0] SEG_OFF   = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [DIG_N-1:0] DIG_OFF   = DIG_ACTIVE_LOW ? {DIG_N{1'b1}} : {DIG_N{1'b0}};
  localparam logic             COLON_ON  = !SEG_ACTIVE_LOW;
  localparam logic             COLON_OFF = SEG_ACTIVE_LOW;

  logic [DIV_W-1:0] r_div;
  dig_idx_e         r_idx;
  logic [7:0]       r_min;
  logic [7:0]       r_sec;
  logic [SEG_W-1:0] r_seg;
  logic [DIG_N-1:0] r_dig;
  logic             r_colon;
  logic             r_frame;

  logic [DIV_W-1:0] w_div_nxt;
  dig_idx_e         w_idx_nxt;
  logic [7:0]       w_min_nxt;
  logic [7:0]       w_sec_nxt;
  logic             w_frame_nxt;
  logic [3:0]       w_nibble;
  logic [SEG_W-1:0] w_seg_hi;
  logic [SEG_W-1:0] w_seg_out;
  logic [DIG_N-1:0] w_dig_on;
  logic [DIG_N-1:0] w_dig_out;
  logic             w_dead;

  bcd_to_seven_seg u_dec (
    .i_nibble (w_nibble),
    .o_seg_c  (w_seg_hi)
  );

  // Next scan position; shadows reload only on the 3->0 slot wrap
  always_comb begin
    w_div_nxt   = r_div + DIV_W'(1);
    w_idx_nxt   = r_idx;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_frame_nxt = 1'b0;
    if (r_div == DIV_LAST) begin
      w_div_nxt = '0;
      w_idx_nxt = dig_idx_e'(r_idx + 2'd1);
      if (r_idx == DIG_MIN_TENS) begin
        w_min_nxt   = min_bcd_i;
        w_sec_nxt   = sec_bcd_i;
        w_frame_nxt = 1'b1;
      end
    end
  end

  // Output image for the upcoming cycle, built from the next scan position
  always_comb begin
    w_nibble = w_sec_nxt[3:0];
    case (w_idx_nxt)
      DIG_SEC_ONES: w_nibble = w_sec_nxt[3:0];
      DIG_SEC_TENS: w_nibble = w_sec_nxt[7:4];
      DIG_MIN_ONES: w_nibble = w_min_nxt[3:0];
      DIG_MIN_TENS: w_nibble = w_min_nxt[7:4];
      default:      w_nibble = w_sec_nxt[3:0];
    endcase

    w_dead   = (DEAD_CLKS != 0) && (w_div_nxt < DEAD_LIM);
    w_dig_on = DIG_N'(1) << w_idx_nxt;
    if (w_dead || blank_i) begin
      w_dig_on = '0;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if ((w_idx_nxt == DIG_MIN_TENS) && (w_min_nxt[7:4] == 4'h0)) begin
      w_dig_on = '0;
    end
`endif

    w_seg_out = SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
    w_dig_out = DIG_ACTIVE_LOW ? ~w_dig_on : w_dig_on;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_idx   <= DIG_SEC_ONES;
      r_min   <= 8'h00;
      r_sec   <= 8'h00;
      r_seg   <= SEG_OFF;
      r_dig   <= DIG_OFF;
      r_colon <= COLON_OFF;
      r_frame <= 1'b0;
    end else begin
      r_div   <= w_div_nxt;
      r_idx   <= w_idx_nxt;
      r_min   <= w_min_nxt;
      r_sec   <= w_sec_nxt;
      r_seg   <= w_seg_out;
      r_dig   <= w_dig_out;
      r_colon <= blank_i ? COLON_OFF : COLON_ON;
      r_frame <= w_frame_nxt;
    end
  end

  assign seg_o   = r_seg;
  assign dig_o   = r_dig;
  assign colon_o = r_colon;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan (SCAN_DIV=4, DEAD_CLKS=1,
// active-low segments and digits). Honours LEADING_ZERO_BLANK_EN.
module tb_seven_seg_scan;

  logic       clk;
  logic       rst;
  logic [7:0] min_bcd_i;
  logic [7:0] sec_bcd_i;
  logic       blank_i;
  logic [6:0] seg_o;
  logic [3:0] dig_o;
  logic       colon_o;
  logic       frame_o;

  int total;
  int bad;

  // Active-low one-hot enable per slot index
  logic [3:0] onehot_low [4];

  seven_seg_scan #(
    .SCAN_DIV       (4),
    .DEAD_CLKS      (1),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .min_bcd_i (min_bcd_i),
    .sec_bcd_i (sec_bcd_i),
    .blank_i   (blank_i),
    .seg_o     (seg_o),
    .dig_o     (dig_o),
    .colon_o   (colon_o),
    .frame_o   (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until frame_o is seen; n returns the number of clocks taken
  task automatic run_to_frame(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (frame_o === 1'b1) break;
    end
    total++;
    if (frame_o !== 1'b1) begin
      bad++;
      $display("FAIL frame_timeout: frame_o=%b after %0d clocks, required 1", frame_o, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    min_bcd_i = 8'h25;
    sec_bcd_i = 8'h00;
    blank_i = 1'b0;
    tick();
    tick();
    total++;
    if (seg_o !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %h want 7f", seg_o); end
    total++;
    if (dig_o !== 4'hF) begin bad++; $display("FAIL reset_dig: got %h want f", dig_o); end
    total++;
    if (colon_o !== 1'b1) begin bad++; $display("FAIL reset_colon: got %b want 1", colon_o); end
    total++;
    if (frame_o !== 1'b0) begin bad++; $display("FAIL reset_frame: got %b want 0", frame_o); end
  endtask

  // First two frames after release: 00:00, then 25:00 latched at clock 16
  task automatic test_first_frames();
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      int         dv;
      int         ix;
      logic [3:0] exp_dig;
      logic [6:0] exp_seg;
      logic       exp_frame;
      tick();
      dv = k % 4;
      ix = (k / 4) % 4;
      exp_dig = (dv == 0) ? 4'hF : onehot_low[ix];
      exp_frame = (k == 16) || (k == 32);
      if (k < 16 || ix <= 1) exp_seg = 7'h40;
      else if (ix == 2)      exp_seg = 7'h12;
      else                   exp_seg = 7'h24;
      total++;
      if (dig_o !== exp_dig) begin bad++; $display("FAIL scan_dig k=%0d: got %h want %h", k, dig_o, exp_dig); end
      total++;
      if (seg_o !== exp_seg) begin bad++; $display("FAIL scan_seg k=%0d: got %h want %h", k, seg_o, exp_seg); end
      total++;
      if (frame_o !== exp_frame) begin bad++; $display("FAIL scan_frame k=%0d: got %b want %b", k, frame_o, exp_frame); end
      total++;
      if (colon_o !== 1'b0) begin bad++; $display("FAIL scan_colon k=%0d: got %b want 0", k, colon_o); end
    end
  endtask

  // Mid-frame seconds change stays hidden until the next frame
  task automatic test_no_tearing();
    int n;
    min_bcd_i = 8'h25;
    sec_bcd_i = 8'h59;
    run_to_frame(n);
    sec_bcd_i = 8'h58;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k <= 3) begin
        total++;
        if (seg_o !== 7'h10) begin bad++; $display("FAIL tear_ones k=%0d: got %h want 10", k, seg_o); end
        total++;
        if (dig_o !== 4'hE) begin bad++; $display("FAIL tear_dig k=%0d: got %h want e", k, dig_o); end
      end
      if (k == 5) begin
        total++;
        if (seg_o !== 7'h12) begin bad++; $display("FAIL tear_tens: got %h want 12", seg_o); end
      end
      total++;
      if (frame_o !== 1'b0) begin bad++; $display("FAIL tear_frame k=%0d: got %b want 0", k, frame_o); end
    end
    run_to_frame(n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL tear_period: got %0d want 1", n); end
    total++;
    if (seg_o !== 7'h00) begin bad++; $display("FAIL tear_new_ones: got %h want 00", seg_o); end
    tick();
    total++;
    if (seg_o !== 7'h00 || dig_o !== 4'hE) begin
      bad++; $display("FAIL tear_new_lit: seg=%h dig=%h want 00/e", seg_o, dig_o);
    end
  endtask

  // Five-cycle blank pulse darkens digits and colon one cycle later
  task automatic test_blank();
    int n;
    run_to_frame(n);
    tick();
    total++;
    if (dig_o !== 4'hE || colon_o !== 1'b0) begin
      bad++; $display("FAIL blank_pre: dig=%h colon=%b want e/0", dig_o, colon_o);
    end
    blank_i = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      tick();
      total++;
      if (dig_o !== 4'hF) begin bad++; $display("FAIL blank_dig k=%0d: got %h want f", k, dig_o); end
      total++;
      if (colon_o !== 1'b1) begin bad++; $display("FAIL blank_colon k=%0d: got %b want 1", k, colon_o); end
    end
    blank_i = 1'b0;
    tick();
    total++;
    if (dig_o !== 4'hD || colon_o !== 1'b0) begin
      bad++; $display("FAIL blank_post: dig=%h colon=%b want d/0", dig_o, colon_o);
    end
    run_to_frame(n);
    total++;
    if (n !== 9) begin bad++; $display("FAIL blank_period: got %0d want 9", n); end
  endtask

  // Dash for non-BCD minutes ones, and leading-zero handling on minute tens
  task automatic test_dash_and_lead_zero();
    int         n;
    logic [3:0] exp_tens_dig;
`ifdef LEADING_ZERO_BLANK_EN
    exp_tens_dig = 4'hF;
`else
    exp_tens_dig = 4'h7;
`endif
    min_bcd_i = 8'h0A;
    sec_bcd_i = 8'h00;
    run_to_frame(n);
    for (int k = 1; k <= 9; k++) tick();
    total++;
    if (seg_o !== 7'h3F) begin bad++; $display("FAIL dash_seg: got %h want 3f", seg_o); end
    total++;
    if (dig_o !== 4'hB) begin bad++; $display("FAIL dash_dig: got %h want b", dig_o); end
    min_bcd_i = 8'h05;
    run_to_frame(n);
    total++;
    if (n !== 7) begin bad++; $display("FAIL dash_period: got %0d want 7", n); end
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 9) begin
        total++;
        if (seg_o !== 7'h12) begin bad++; $display("FAIL lz_ones_seg: got %h want 12", seg_o); end
      end
      if (k == 13) begin
        total++;
        if (seg_o !== 7'h40) begin bad++; $display("FAIL lz_tens_seg: got %h want 40", seg_o); end
      end
      if (k >= 13) begin
        total++;
        if (dig_o !== exp_tens_dig) begin
          bad++; $display("FAIL lz_tens_dig k=%0d: got %h want %h", k, dig_o, exp_tens_dig);
        end
      end
    end
  endtask

  // Async reset in slot 2 blanks outputs at once; scan restarts at digit 0
  task automatic test_reset_mid_slot();
    int n;
    min_bcd_i = 8'h25;
    sec_bcd_i = 8'h00;
    run_to_frame(n);
    for (int k = 1; k <= 9; k++) tick();
    total++;
    if (dig_o !== 4'hB) begin bad++; $display("FAIL rmid_pre: got %h want b", dig_o); end
    rst = 1'b1;
    #1;
    total++;
    if (dig_o !== 4'hF || seg_o !== 7'h7F || colon_o !== 1'b1 || frame_o !== 1'b0) begin
      bad++; $display("FAIL rmid_async: dig=%h seg=%h colon=%b frame=%b want f/7f/1/0",
                      dig_o, seg_o, colon_o, frame_o);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (dig_o !== 4'hE || seg_o !== 7'h40 || colon_o !== 1'b0) begin
      bad++; $display("FAIL rmid_restart: dig=%h seg=%h colon=%b want e/40/0", dig_o, seg_o, colon_o);
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        total++;
        if (dig_o !== 4'hF) begin bad++; $display("FAIL rmid_dead: got %h want f", dig_o); end
      end
      if (k == 5) begin
        total++;
        if (dig_o !== 4'hD) begin bad++; $display("FAIL rmid_slot1: got %h want d", dig_o); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    onehot_low[0] = 4'hE;
    onehot_low[1] = 4'hD;
    onehot_low[2] = 4'hB;
    onehot_low[3] = 4'h7;
    test_reset();
    test_first_frames();
    test_no_tearing();
    test_blank();
    test_dash_and_lead_zero();
    test_reset_mid_slot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
